// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter for one shared 1-cycle synchronous memory port with bounded bursts.
module mem_port_arbiter #(
  parameter int NB        = 32,
  parameter int NB_ADDR   = 10,
  parameter int MAX_BURST = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_a,
  input  logic               i_req_b,
  input  logic [NB_ADDR-1:0] i_addr_a,
  input  logic [NB_ADDR-1:0] i_addr_b,
  input  logic [NB-1:0]      i_wdata_a,
  input  logic [NB-1:0]      i_wdata_b,
  input  logic               i_we_a,
  input  logic               i_we_b,
  input  logic [NB-1:0]      i_mem_rdata,
  output logic               o_gnt_a,
  output logic               o_gnt_b,
  output logic               o_sel,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB-1:0]      o_mem_wdata,
  output logic               o_mem_we,
  output logic [NB-1:0]      o_rdata_a,
  output logic [NB-1:0]      o_rdata_b,
  output logic               o_valid_a,
  output logic               o_valid_b
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic [NB-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic acc_a, acc_b, sat;
  always_comb begin
    acc_a = (state_q == OWN_A) && i_req_a;
    acc_b = (state_q == OWN_B) && i_req_b;
    sat = cnt_q == 8'(MAX_BURST - 1);
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = (i_req_a && i_req_b) ? (last_q ? OWN_A : OWN_B) :
                       i_req_a ? OWN_A : i_req_b ? OWN_B : IDLE;
      OWN_A: state_d = !i_req_a ? (i_req_b ? OWN_B : IDLE) : (sat && i_req_b) ? OWN_B : OWN_A;
      OWN_B: state_d = !i_req_b ? (i_req_a ? OWN_A : IDLE) : (sat && i_req_a) ? OWN_A : OWN_B;
      default: state_d = IDLE;
    endcase
    // last_q: 1 means B owned last, so a tie from IDLE goes to A
    last_d = (state_d == OWN_B) ? 1'b1 : (state_d == OWN_A) ? 1'b0 : last_q;
    cnt_d = (state_d != state_q) ? 8'd0 : ((acc_a || acc_b) && !sat) ? cnt_q + 8'd1 : cnt_q;
    vld_a_d = acc_a && !i_we_a;
    vld_b_d = acc_b && !i_we_b;
    hold_a_d = vld_a_q ? i_mem_rdata : hold_a_q;
    hold_b_d = vld_b_q ? i_mem_rdata : hold_b_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= 8'd0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
    end
  end
  assign o_gnt_a = state_q == OWN_A;
  assign o_gnt_b = state_q == OWN_B;
  assign o_sel = o_gnt_b;
  assign o_mem_addr = acc_b ? i_addr_b : i_addr_a;
  assign o_mem_wdata = acc_b ? i_wdata_b : i_wdata_a;
  assign o_mem_we = acc_a ? i_we_a : acc_b ? i_we_b : 1'b0;
  assign o_valid_a = vld_a_q;
  assign o_valid_b = vld_b_q;
  assign o_rdata_a = vld_a_q ? i_mem_rdata : hold_a_q;
  assign o_rdata_b = vld_b_q ? i_mem_rdata : hold_b_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed stimulus against a tenure-level reference model with a read-return scoreboard.
module tb_mem_port_arbiter;
  localparam int NB = 32;
  localparam int NA = 10;
  localparam int MB = 4;
  logic i_clk, i_reset, i_req_a, i_req_b, i_we_a, i_we_b;
  logic [NA-1:0] i_addr_a, i_addr_b, o_mem_addr;
  logic [NB-1:0] i_wdata_a, i_wdata_b, i_mem_rdata, o_mem_wdata, o_rdata_a, o_rdata_b;
  logic o_gnt_a, o_gnt_b, o_sel, o_mem_we, o_valid_a, o_valid_b;

  mem_port_arbiter #(.NB(NB), .NB_ADDR(NA), .MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_addr_a(i_addr_a), .i_addr_b(i_addr_b),
    .i_wdata_a(i_wdata_a), .i_wdata_b(i_wdata_b),
    .i_we_a(i_we_a), .i_we_b(i_we_b),
    .i_mem_rdata(i_mem_rdata),
    .o_gnt_a(o_gnt_a), .o_gnt_b(o_gnt_b), .o_sel(o_sel),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .o_rdata_a(o_rdata_a), .o_rdata_b(o_rdata_b),
    .o_valid_a(o_valid_a), .o_valid_b(o_valid_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [NB-1:0] mem [1024];
  logic [NB-1:0] mmem [1024];
  always @(posedge i_clk) begin
    i_mem_rdata <= mem[o_mem_addr];
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
  end

  logic rst_seen;
  always @(posedge i_clk) rst_seen <= i_reset;

  typedef struct {
    int side;
    logic [NB-1:0] data;
    int cyc;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int own = 0;
  int last = 2;
  int run = 0;
  logic [NB-1:0] la = '0;
  logic [NB-1:0] lb = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic step(input logic ra, input logic rb, input logic wa, input logic wb,
                      input logic [NA-1:0] aa, input logic [NA-1:0] ab,
                      input logic [NB-1:0] da, input logic [NB-1:0] db, input logic rst);
    logic req_own, req_oth, iss, xw;
    logic [NA-1:0] xa;
    logic [NB-1:0] xd;
    int oth, nxt;
    exp_t e;
    @(posedge i_clk);
    #1;
    cyc++;
    i_reset = rst; i_req_a = ra; i_req_b = rb; i_we_a = wa; i_we_b = wb;
    i_addr_a = aa; i_addr_b = ab; i_wdata_a = da; i_wdata_b = db;
    oth = 3 - own;
    req_own = (own == 1) ? ra : (own == 2) ? rb : 1'b0;
    req_oth = (own == 1) ? rb : ra;
    iss = (own != 0) && req_own;
    xa = (iss && own == 2) ? ab : aa;
    xd = (iss && own == 2) ? db : da;
    xw = iss && ((own == 1) ? wa : wb);
    #1;
    chk("gnt_a", 64'(o_gnt_a), 64'(own == 1));
    chk("gnt_b", 64'(o_gnt_b), 64'(own == 2));
    chk("sel", 64'(o_sel), 64'(own == 2));
    chk("mem_we", 64'(o_mem_we), 64'(xw));
    chk("mem_addr", 64'(o_mem_addr), 64'(xa));
    chk("mem_wdata", 64'(o_mem_wdata), 64'(xd));
    if (iss && !xw && !rst) begin
      e.side = own;
      e.data = mmem[xa];
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    if (xw) mmem[xa] = xd;
    if (rst) begin
      own = 0; last = 2; run = 0;
    end else begin
      if (own == 0) nxt = (ra && rb) ? 3 - last : ra ? 1 : rb ? 2 : 0;
      else if (!req_own) nxt = req_oth ? oth : 0;
      else nxt = (run >= MB - 1 && req_oth) ? oth : own;
      if (nxt != own) begin
        run = 0;
        if (nxt != 0) last = nxt;
      end else if (iss) run++;
      own = nxt;
    end
  endtask

  task automatic idle(input int n, input logic rst);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, '0, rst);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (rst_seen === 1'b1) begin
        la = '0; lb = '0;
      end
      if (o_valid_a && o_valid_b) chk("both_valid", 64'(1), 64'(0));
      if (o_valid_a || o_valid_b) begin
        if (q.size() == 0) chk("unexpected_valid", 64'(o_valid_b ? 2 : 1), 64'(0));
        else begin
          e = q.pop_front();
          chk("valid_side", 64'(o_valid_b ? 2 : 1), 64'(e.side));
          chk("valid_cycle", 64'(cyc), 64'(e.cyc));
          chk("rdata", 64'(o_valid_a ? o_rdata_a : o_rdata_b), 64'(e.data));
          if (o_valid_a) la = e.data; else lb = e.data;
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("missing_valid", 64'(0), 64'(e.side));
      end
      if (!o_valid_a) chk("hold_a", 64'(o_rdata_a), 64'(la));
      if (!o_valid_b) chk("hold_b", 64'(o_rdata_b), 64'(lb));
    end
  end

  initial begin
    i_reset = 1'b1; i_req_a = 0; i_req_b = 0; i_we_a = 0; i_we_b = 0;
    i_addr_a = '0; i_addr_b = '0; i_wdata_a = '0; i_wdata_b = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1234;
      mmem[i] = mem[i];
    end
    idle(2, 1);
    idle(1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 10'd5, '0, '0, '0, 0);
    idle(2, 0);
    idle(1, 1);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 10'(i), 10'(100 + i), '0, '0, 0);
    idle(2, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, '0, 10'h3FF, '0, 32'd80, 0);
    idle(2, 0);
    step(1, 0, 0, 0, 10'h3FF, '0, '0, '0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 10'(i), '0, '0, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 10'(20 + i), 10'(40 + i), '0, '0, 0);
    idle(2, 0);
    step(0, 1, 0, 0, '0, 10'd7, '0, '0, 0);
    step(0, 1, 0, 0, '0, 10'd8, '0, '0, 0);
    step(0, 1, 0, 0, '0, 10'd9, '0, '0, 1);
    step(0, 1, 0, 0, '0, 10'd9, '0, '0, 0);
    idle(2, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
           $urandom, $urandom, $urandom_range(0, 59) == 0);
    idle(4, 0);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
